// File: rtl/c32_prefetch.sv
// Instruction prefetch queue for the c32 core: fetches aligned words ahead of
// execution and presents a little-endian byte window at the current EIP.
module c32_prefetch #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    output logic [31:0] mem_a,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [31:0] mem_i,
    input  logic        flush,
    input  logic [31:0] flush_eip,
    input  logic [2:0]  consume,
    output logic [31:0] out_data,
    output logic [2:0]  out_cnt,
    output logic [31:0] out_eip
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FILL_LIMIT = LW'(DEPTH - 4);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic          drop_r, drop_s;
    logic [1:0]    skip_r, skip_s;
    logic [31:0]   fetch_ptr_r, fetch_ptr_s;
    logic [31:0]   mem_a_r, mem_a_s;
    logic          mem_rd_r, mem_rd_s;
    logic [PW-1:0] head_r, head_s;
    logic [PW-1:0] tail_r, tail_s;
    logic [LW-1:0] level_r, level_s;
    logic [7:0]    buf_r [DEPTH];
    logic [7:0]    buf_s [DEPTH];
    logic [31:0]   out_data_r, out_data_s;
    logic [2:0]    out_cnt_r, out_cnt_s;
    logic [31:0]   out_eip_r, out_eip_s;
    logic          push_s;
    logic [LW-1:0] consume_ext_s;
    logic [LW-1:0] pop_n_s;
    logic [2:0]    push_n_s;

    // Pop amount clamped to the bytes held; push amount skips leading bytes after a redirect
    always_comb begin
        consume_ext_s = LW'(consume);
        if (consume_ext_s < level_r) begin
            pop_n_s = consume_ext_s;
        end else begin
            pop_n_s = level_r;
        end
        push_n_s = 3'd4 - {1'b0, skip_r};
    end

    // Fetch FSM, queue pointers and EIP tracking; flush overrides push and pop
    always_comb begin
        state_s     = state_r;
        drop_s      = drop_r;
        skip_s      = skip_r;
        fetch_ptr_s = fetch_ptr_r;
        head_s      = head_r;
        tail_s      = tail_r;
        level_s     = level_r;
        out_eip_s   = out_eip_r;
        push_s      = 1'b0;
        mem_a_s     = mem_a_r;
        if (flush) begin
            head_s      = {PW{1'b0}};
            tail_s      = {PW{1'b0}};
            level_s     = {LW{1'b0}};
            out_eip_s   = flush_eip;
            fetch_ptr_s = {flush_eip[31:2], 2'b00};
            skip_s      = flush_eip[1:0];
            if (state_r == ST_REQ) begin
                if (mem_ack) begin
                    state_s = ST_IDLE;
                    drop_s  = 1'b0;
                end else begin
                    // Bus request must complete; its data is discarded when it lands
                    drop_s  = 1'b1;
                end
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            head_s    = head_r + PW'(pop_n_s);
            level_s   = level_r - pop_n_s;
            out_eip_s = out_eip_r + 32'(pop_n_s);
            case (state_r)
                ST_IDLE: begin
                    if (level_r <= FILL_LIMIT) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_s = ST_IDLE;
                        if (drop_r) begin
                            drop_s = 1'b0;
                        end else begin
                            push_s      = 1'b1;
                            tail_s      = tail_r + PW'(push_n_s);
                            level_s     = level_r - pop_n_s + LW'(push_n_s);
                            fetch_ptr_s = fetch_ptr_r + 32'd4;
                            skip_s      = 2'b00;
                        end
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        // Address is frozen while a request is outstanding, otherwise it tracks the fetch pointer
        if ((state_r == ST_REQ) && (state_s == ST_REQ)) begin
            mem_a_s = mem_a_r;
        end else begin
            mem_a_s = fetch_ptr_s;
        end
        mem_rd_s = (state_s == ST_REQ);
    end

    // Byte storage update: accepted word bytes skip..3 land at tail onwards
    always_comb begin : buf_write
        logic [PW-1:0] offs_s;
        logic [1:0]    sel_s;
        for (int k = 0; k < DEPTH; k++) begin
            offs_s = PW'(k) - tail_r;
            sel_s  = offs_s[1:0] + skip_r;
            if (push_s && (offs_s < PW'(push_n_s))) begin
                buf_s[k] = mem_i[{sel_s, 3'b000} +: 8];
            end else begin
                buf_s[k] = buf_r[k];
            end
        end
    end

    // Output window built from next-state queue contents so it is valid with the level change
    always_comb begin
        out_data_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (LW'(i) < level_s) begin
                out_data_s[8*i +: 8] = buf_s[head_s + PW'(i)];
            end else begin
                out_data_s[8*i +: 8] = 8'h00;
            end
        end
        if (level_s >= LW'(3'd4)) begin
            out_cnt_s = 3'd4;
        end else begin
            out_cnt_s = level_s[2:0];
        end
    end

    // State and output registers, frozen while ce is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            drop_r      <= 1'b0;
            skip_r      <= RESET_EIP[1:0];
            fetch_ptr_r <= {RESET_EIP[31:2], 2'b00};
            mem_a_r     <= {RESET_EIP[31:2], 2'b00};
            mem_rd_r    <= 1'b0;
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_data_r  <= 32'h0000_0000;
            out_cnt_r   <= 3'd0;
            out_eip_r   <= RESET_EIP;
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else if (ce) begin
            state_r     <= state_s;
            drop_r      <= drop_s;
            skip_r      <= skip_s;
            fetch_ptr_r <= fetch_ptr_s;
            mem_a_r     <= mem_a_s;
            mem_rd_r    <= mem_rd_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            level_r     <= level_s;
            out_data_r  <= out_data_s;
            out_cnt_r   <= out_cnt_s;
            out_eip_r   <= out_eip_s;
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= buf_s[i];
            end
        end
    end

    assign mem_a    = mem_a_r;
    assign mem_rd   = mem_rd_r;
    assign out_data = out_data_r;
    assign out_cnt  = out_cnt_r;
    assign out_eip  = out_eip_r;

endmodule
